// File: rtl/coin_sprite_sequencer.sv
// Coin sprite sequencer: per-pixel coin hit detection, sprite ROM addressing with animation,
// and per-coin life tracking (ACTIVE / VANISH blink / IDLE) feeding the coin colour palette.
module coin_sprite_sequencer #(
    parameter int unsigned NUM_COINS     = 4,
    parameter int unsigned SPRITE_W      = 16,
    parameter int unsigned SPRITE_H      = 16,
    parameter int unsigned NUM_FRAMES    = 4,
    parameter int unsigned FRAME_HOLD    = 8,
    parameter int unsigned VANISH_FRAMES = 16,
    parameter int unsigned ROM_AW        = 10
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 frame_start,
    input  logic                                 pix_en,
    input  logic [9:0]                           DrawX,
    input  logic [9:0]                           DrawY,
    input  logic [NUM_COINS*10-1:0]              coin_x,
    input  logic [NUM_COINS*10-1:0]              coin_y,
    input  logic                                 coin_load,
    input  logic [NUM_COINS-1:0]                 collect,
    output logic [ROM_AW-1:0]                    rom_addr,
    input  logic [3:0]                           rom_data,
    output logic [3:0]                           pal_index,
    output logic                                 coin_pix_valid,
    output logic [$clog2(NUM_COINS+1)-1:0]       coins_left,
    output logic [$clog2(NUM_FRAMES)-1:0]        anim_frame
);

    localparam int unsigned WW  = $clog2(SPRITE_W);
    localparam int unsigned HW  = $clog2(SPRITE_H);
    localparam int unsigned FW  = $clog2(NUM_FRAMES);
    localparam int unsigned VW  = $clog2(VANISH_FRAMES);
    localparam int unsigned HLW = $clog2(FRAME_HOLD);
    localparam int unsigned CLW = $clog2(NUM_COINS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_VANISH = 2'd2;

    logic [1:0]     state      [NUM_COINS];
    logic [1:0]     state_nxt  [NUM_COINS];
    logic [VW-1:0]  vcnt       [NUM_COINS];
    logic [VW-1:0]  vcnt_nxt   [NUM_COINS];
    logic [9:0]     pos_x      [NUM_COINS];
    logic [9:0]     pos_y      [NUM_COINS];

    logic [NUM_COINS-1:0] vis;
    logic                 hit;
    logic [WW-1:0]        dx_sel;
    logic [HW-1:0]        dy_sel;
    logic [CLW-1:0]       active_cnt;
    logic [HLW-1:0]       hold_cnt;
    logic                 v1;
    logic                 v2;

    // Per-coin life FSM next state; coin_load overrides everything, including a same-cycle collect.
    always_comb begin
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            state_nxt[i] = state[i];
            vcnt_nxt[i]  = vcnt[i];
            if (coin_load) begin
                state_nxt[i] = ST_ACTIVE;
                vcnt_nxt[i]  = '0;
            end else begin
                case (state[i])
                    ST_ACTIVE: begin
                        if (collect[i]) begin
                            state_nxt[i] = ST_VANISH;
                            vcnt_nxt[i]  = '0;
                        end
                    end
                    ST_VANISH: begin
                        if (frame_start) begin
                            if (vcnt[i] == VW'(VANISH_FRAMES - 1)) begin
                                state_nxt[i] = ST_IDLE;
                                vcnt_nxt[i]  = '0;
                            end else begin
                                vcnt_nxt[i] = vcnt[i] + VW'(1);
                            end
                        end
                    end
                    ST_IDLE: ;
                    default: begin
                        state_nxt[i] = ST_IDLE;
                        vcnt_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(NUM_COINS); i++) begin
                state[i] <= ST_IDLE;
                vcnt[i]  <= '0;
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_COINS); i++) begin
                state[i] <= state_nxt[i];
                vcnt[i]  <= vcnt_nxt[i];
                if (coin_load) begin
                    pos_x[i] <= coin_x[10*i +: 10];
                    pos_y[i] <= coin_y[10*i +: 10];
                end
            end
        end
    end

    // Visibility, ACTIVE count, and lowest-index hit; offsets only need the low sprite bits.
    always_comb begin
        vis        = '0;
        active_cnt = '0;
        hit        = 1'b0;
        dx_sel     = '0;
        dy_sel     = '0;
        for (int i = int'(NUM_COINS) - 1; i >= 0; i--) begin
            vis[i] = (state[i] == ST_ACTIVE) || ((state[i] == ST_VANISH) && !vcnt[i][0]);
            if (state[i] == ST_ACTIVE) begin
                active_cnt = active_cnt + CLW'(1);
            end
            if (vis[i]
                && ({1'b0, DrawX} >= {1'b0, pos_x[i]})
                && ({1'b0, DrawX} <  {1'b0, pos_x[i]} + 11'(SPRITE_W))
                && ({1'b0, DrawY} >= {1'b0, pos_y[i]})
                && ({1'b0, DrawY} <  {1'b0, pos_y[i]} + 11'(SPRITE_H))) begin
                hit    = 1'b1;
                dx_sel = DrawX[WW-1:0] - pos_x[i][WW-1:0];
                dy_sel = DrawY[HW-1:0] - pos_y[i][HW-1:0];
            end
        end
    end

    // Three-stage pixel pipeline around the registered-read sprite ROM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1             <= 1'b0;
            v2             <= 1'b0;
            rom_addr       <= '0;
            pal_index      <= '0;
            coin_pix_valid <= 1'b0;
        end else begin
            v1 <= pix_en && hit;
            if (pix_en && hit) begin
                rom_addr <= ROM_AW'({anim_frame, dy_sel, dx_sel});
            end
            v2             <= v1;
            coin_pix_valid <= v2 && (rom_data != 4'd0);
            pal_index      <= (v2 && (rom_data != 4'd0)) ? rom_data : 4'd0;
        end
    end

    // Animation frame advances only on frame_start, so it never changes mid-frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_cnt   <= '0;
            anim_frame <= '0;
        end else if (coin_load) begin
            hold_cnt   <= '0;
            anim_frame <= '0;
        end else if (frame_start) begin
            if (hold_cnt == HLW'(FRAME_HOLD - 1)) begin
                hold_cnt   <= '0;
                anim_frame <= anim_frame + FW'(1);
            end else begin
                hold_cnt <= hold_cnt + HLW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            coins_left <= '0;
        end else begin
            coins_left <= active_cnt;
        end
    end

endmodule

// File: tb/tb_coin_sprite_sequencer.sv
// Directed bench for coin_sprite_sequencer: table of pixel vectors plus hand-written
// sequences for animation, collect/vanish blinking, load/collect priority and mid-run reset.
module tb_coin_sprite_sequencer;

    logic        Clk;
    logic        Reset;
    logic        frame_start;
    logic        pix_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [39:0] coin_x;
    logic [39:0] coin_y;
    logic        coin_load;
    logic [3:0]  collect;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pal_index;
    logic        coin_pix_valid;
    logic [2:0]  coins_left;
    logic [1:0]  anim_frame;

    coin_sprite_sequencer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_start    (frame_start),
        .pix_en         (pix_en),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .coin_x         (coin_x),
        .coin_y         (coin_y),
        .coin_load      (coin_load),
        .collect        (collect),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .pal_index      (pal_index),
        .coin_pix_valid (coin_pix_valid),
        .coins_left     (coins_left),
        .anim_frame     (anim_frame)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_word(input int a);
        if (a == 0) return 4'd7;
        if (a == 5) return 4'd0;
        return 4'((a % 15) + 1);
    endfunction

    logic [3:0] rom_mem [1024];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] addr;
        logic       valid;
        logic [3:0] pal;
    } vec_t;

    vec_t vecs [12];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   pulse_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pulse_cnt++;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y,
                         output logic [9:0] a, output logic [3:0] p, output logic v);
        pix_en = 1'b1;
        DrawX  = x;
        DrawY  = y;
        step();
        a      = rom_addr;
        pix_en = 1'b0;
        step();
        step();
        p = pal_index;
        v = coin_pix_valid;
    endtask

    task automatic pulse_collect(input logic [3:0] c, input logic ld);
        collect   = c;
        coin_load = ld;
        step();
        collect   = '0;
        coin_load = 1'b0;
        step();
    endtask

    logic [9:0] a;
    logic [3:0] p;
    logic       v;
    int         exp_anim;

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = rom_word(i);
        //        x      y      addr   valid  pal
        vecs[0]  = '{10'd100,  10'd50,  10'd0,   1'b1, 4'd7};
        vecs[1]  = '{10'd105,  10'd55,  10'd85,  1'b1, 4'd11};
        vecs[2]  = '{10'd116,  10'd50,  10'd85,  1'b0, 4'd0};
        vecs[3]  = '{10'd105,  10'd50,  10'd5,   1'b0, 4'd0};
        vecs[4]  = '{10'd93,   10'd44,  10'd1,   1'b1, 4'd2};
        vecs[5]  = '{10'd115,  10'd65,  10'd255, 1'b1, 4'd1};
        vecs[6]  = '{10'd100,  10'd66,  10'd255, 1'b0, 4'd0};
        vecs[7]  = '{10'd99,   10'd50,  10'd103, 1'b1, 4'd14};
        vecs[8]  = '{10'd300,  10'd200, 10'd0,   1'b1, 4'd7};
        vecs[9]  = '{10'd1023, 10'd415, 10'd248, 1'b1, 4'd9};
        vecs[10] = '{10'd5,    10'd400, 10'd248, 1'b0, 4'd0};
        vecs[11] = '{10'd1014, 10'd400, 10'd248, 1'b0, 4'd0};

        Reset       = 1'b1;
        frame_start = 1'b0;
        pix_en      = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        coin_x      = {10'd1015, 10'd300, 10'd92, 10'd100};
        coin_y      = {10'd400,  10'd200, 10'd44, 10'd50};
        coin_load   = 1'b0;
        collect     = '0;
        step();
        step();
        Reset = 1'b0;
        step();

        check("reset_coins_left", int'(coins_left), 0);
        check("reset_anim", int'(anim_frame), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_pal", int'(pal_index), 0);
        check("reset_valid", int'(coin_pix_valid), 0);

        pulse_collect(4'b0000, 1'b1);
        pulse_cnt = 0;
        check("load_coins_left", int'(coins_left), 4);
        check("load_anim", int'(anim_frame), 0);
        check("load_valid", int'(coin_pix_valid), 0);

        for (int i = 0; i < 12; i++) begin
            pixel(vecs[i].x, vecs[i].y, a, p, v);
            check($sformatf("vec%0d_addr", i), int'(a), int'(vecs[i].addr));
            check($sformatf("vec%0d_valid", i), int'(v), int'(vecs[i].valid));
            check($sformatf("vec%0d_pal", i), int'(p), int'(vecs[i].pal));
        end

        for (int i = 0; i < 7; i++) frame_pulse();
        check("anim_after7", int'(anim_frame), 0);
        frame_pulse();
        check("anim_after8", int'(anim_frame), 1);
        pixel(10'd100, 10'd50, a, p, v);
        check("anim1_addr", int'(a), 256);
        check("anim1_pal", int'(p), 2);
        for (int i = 0; i < 24; i++) frame_pulse();
        check("anim_after32", int'(anim_frame), 0);

        // Coin 2 collected: blinks on vanish count parity, then goes IDLE after 16 frames.
        pulse_collect(4'b0100, 1'b0);
        check("collect_coins_left", int'(coins_left), 3);
        pixel(10'd300, 10'd200, a, p, v);
        check("vanish0_valid", int'(v), 1);
        exp_anim = (pulse_cnt / 8) % 4;
        check("vanish0_pal", int'(p), int'(rom_word(exp_anim * 256)));
        frame_pulse();
        pixel(10'd300, 10'd200, a, p, v);
        check("vanish1_valid", int'(v), 0);
        pulse_collect(4'b0100, 1'b0);
        check("recollect_coins_left", int'(coins_left), 3);
        pixel(10'd300, 10'd200, a, p, v);
        check("recollect_hidden", int'(v), 0);
        for (int i = 0; i < 13; i++) frame_pulse();
        pixel(10'd300, 10'd200, a, p, v);
        check("vanish14_valid", int'(v), 1);
        exp_anim = (pulse_cnt / 8) % 4;
        check("anim_model", int'(anim_frame), exp_anim);
        check("vanish14_pal", int'(p), int'(rom_word(exp_anim * 256)));
        frame_pulse();
        pixel(10'd300, 10'd200, a, p, v);
        check("vanish15_valid", int'(v), 0);
        frame_pulse();
        pixel(10'd300, 10'd200, a, p, v);
        check("idle_valid", int'(v), 0);
        frame_pulse();
        pixel(10'd300, 10'd200, a, p, v);
        check("idle_stays_hidden", int'(v), 0);
        check("idle_coins_left", int'(coins_left), 3);

        pulse_collect(4'b0001, 1'b1);
        pulse_cnt = 0;
        check("load_beats_collect", int'(coins_left), 4);
        check("reload_anim", int'(anim_frame), 0);
        pixel(10'd300, 10'd200, a, p, v);
        check("reload_coin2_valid", int'(v), 1);
        check("reload_coin2_pal", int'(p), 7);

        // Asynchronous reset with the pipeline streaming opaque pixels.
        pix_en = 1'b1;
        DrawX  = 10'd100;
        DrawY  = 10'd50;
        for (int i = 0; i < 4; i++) step();
        check("stream_valid", int'(coin_pix_valid), 1);
        check("stream_pal", int'(pal_index), 7);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_valid", int'(coin_pix_valid), 0);
        check("async_rst_pal", int'(pal_index), 0);
        check("async_rst_addr", int'(rom_addr), 0);
        check("async_rst_coins_left", int'(coins_left), 0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("post_rst_idle_valid", int'(coin_pix_valid), 0);
        check("post_rst_coins_left", int'(coins_left), 0);
        pix_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
